// File: rtl/stacked_data_memory_if.sv
// rtl/stacked_data_memory_if.sv - request/response bus of the stacked heap/stack data memory
interface stacked_data_memory_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/stacked_data_memory.sv
// rtl/stacked_data_memory.sv - byte-addressed data memory split into heap (addr >= 0) and stack (addr < 0)
// Optional STACKED_MEM_STATS_EN adds load/store/error counters.
module stacked_data_memory #(
  parameter int ADDR_W      = 16,
  parameter int HEAP_DEPTH  = 64,
  parameter int STACK_DEPTH = 64,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  stacked_data_memory_if.slave   bus,
  output logic                   init_done
`ifdef STACKED_MEM_STATS_EN
  ,
  output logic [31:0]            load_count,
  output logic [31:0]            store_count,
  output logic [31:0]            error_count
`endif
);

  localparam int MAX_DEPTH = (HEAP_DEPTH > STACK_DEPTH) ? HEAP_DEPTH : STACK_DEPTH;
  localparam int CNT_W     = $clog2(MAX_DEPTH + 1);
  localparam int HIDX_W    = (HEAP_DEPTH > 1) ? $clog2(HEAP_DEPTH) : 1;
  localparam int SIDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [CNT_W-1:0] HEAP_LIM  = CNT_W'(HEAP_DEPTH);
  localparam logic [CNT_W-1:0] STACK_LIM = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clear_en;
  logic              ready;

  logic [31:0] heap_mem  [HEAP_DEPTH];
  logic [31:0] stack_mem [STACK_DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clear_en  = 1'b0;
    ready     = 1'b0;
    init_done = 1'b0;
    case (state_q)
      S_INIT: begin
        if (INIT_CLEAR != 0) begin
          clear_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ready     = 1'b1;
        init_done = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign bus.req_ready = ready;

  // Word index is the arithmetic shift of the signed address; negative indices count down from the stack top.
  logic signed [31:0] addr_ext;
  logic signed [31:0] widx;
  logic [1:0]         off;
  logic               is_stack;
  logic [HIDX_W-1:0]  hidx;
  logic [SIDX_W-1:0]  sidx;
  logic               range_ok;
  logic               size_ok;
  logic               legal;
  logic               accept;

  assign addr_ext = $signed({{(32-ADDR_W){bus.req_addr[ADDR_W-1]}}, bus.req_addr});
  assign widx     = addr_ext >>> 2;
  assign off      = bus.req_addr[1:0];
  assign is_stack = bus.req_addr[ADDR_W-1];
  assign hidx     = HIDX_W'(widx);
  assign sidx     = SIDX_W'(widx + STACK_DEPTH);
  assign range_ok = is_stack ? (widx >= -STACK_DEPTH) : (widx < HEAP_DEPTH);

  always_comb begin
    size_ok = 1'b0;
    case (bus.req_size)
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = ~off[0];
      2'b10:   size_ok = (off == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end

  assign legal  = range_ok & size_ok;
  assign accept = bus.req_valid & ready;

  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [31:0] ld_data;
  logic        we_heap;
  logic        we_stack;

  assign rd_word = is_stack ? stack_mem[sidx] : heap_mem[hidx];

  // Stores merge into the current word so untouched lanes keep their contents.
  always_comb begin
    wr_word = rd_word;
    case (bus.req_size)
      2'b00:   wr_word[{off, 3'b000} +: 8]        = bus.req_wdata[7:0];
      2'b01:   wr_word[{off[1], 4'b0000} +: 16]   = bus.req_wdata[15:0];
      default: wr_word = bus.req_wdata;
    endcase
  end

  always_comb begin
    ld_data = rd_word;
    case (bus.req_size)
      2'b00: begin
        ld_data = {24'd0, rd_word[{off, 3'b000} +: 8]};
        if (!bus.req_unsigned) ld_data[31:8] = {24{ld_data[7]}};
      end
      2'b01: begin
        ld_data = {16'd0, rd_word[{off[1], 4'b0000} +: 16]};
        if (!bus.req_unsigned) ld_data[31:16] = {16{ld_data[15]}};
      end
      default: ld_data = rd_word;
    endcase
  end

  assign we_heap  = accept & legal & bus.req_write & ~is_stack;
  assign we_stack = accept & legal & bus.req_write & is_stack;

  always_ff @(posedge clock) begin
    if (clear_en && (cnt_q < HEAP_LIM))
      heap_mem[HIDX_W'(cnt_q)] <= '0;
    else if (we_heap)
      heap_mem[hidx] <= wr_word;
  end

  always_ff @(posedge clock) begin
    if (clear_en && (cnt_q < STACK_LIM))
      stack_mem[SIDX_W'(cnt_q)] <= '0;
    else if (we_stack)
      stack_mem[sidx] <= wr_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_rdata <= (accept && legal && !bus.req_write) ? ld_data : 32'd0;
      bus.rsp_error <= accept & ~legal;
    end
  end

`ifdef STACKED_MEM_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
      error_count <= '0;
    end else if (accept) begin
      if (!legal)              error_count <= error_count + 32'd1;
      else if (bus.req_write)  store_count <= store_count + 32'd1;
      else                     load_count  <= load_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stacked_data_memory.sv
// tb/tb_stacked_data_memory.sv - directed bench for stacked_data_memory
module tb_stacked_data_memory;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic init_done;
  int   tests  = 0;
  int   failed = 0;

  always #5 clock = ~clock;

  stacked_data_memory_if #(.ADDR_W(16)) bus();

`ifdef STACKED_MEM_STATS_EN
  logic [31:0] load_count, store_count, error_count;
`endif

  stacked_data_memory #(
    .ADDR_W(16), .HEAP_DEPTH(64), .STACK_DEPTH(64), .INIT_CLEAR(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .init_done(init_done)
`ifdef STACKED_MEM_STATS_EN
    ,
    .load_count(load_count),
    .store_count(store_count),
    .error_count(error_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request for exactly one clock edge; the response is visible on return.
  task automatic req(input logic wr, input logic [1:0] sz, input logic un,
                     input logic [15:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic rsp(input string tag, input logic [31:0] rdata, input logic err);
    chk({tag, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, ".rdata"}, bus.rsp_rdata, rdata);
    chk({tag, ".error"}, {31'd0, bus.rsp_error}, {31'd0, err});
  endtask

  // Counts clock edges until req_ready rises, flagging any response seen meanwhile.
  task automatic wait_init(input string tag);
    int n;
    int spurious;
    n = 0;
    spurious = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (bus.rsp_valid) spurious++;
    end while (!bus.req_ready && n < 200);
    chk({tag, ".init_cycles"}, n, 64);
    chk({tag, ".init_done"}, {31'd0, init_done}, 32'd1);
    chk({tag, ".no_rsp_in_init"}, spurious, 0);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("reset.req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("reset.init_done", {31'd0, init_done}, 32'd0);
    chk("reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset.rsp_error", {31'd0, bus.rsp_error}, 32'd0);

    @(negedge clock);
    reset = 1'b0;
    wait_init("init1");

    req(1'b0, 2'b10, 1'b0, 16'h0010, 32'd0);
    rsp("lw_0010_cleared", 32'h0000_0000, 1'b0);

    req(1'b1, 2'b10, 1'b0, 16'h0008, 32'h1234_5678);
    rsp("sw_0008", 32'd0, 1'b0);
    req(1'b0, 2'b00, 1'b1, 16'h000B, 32'd0);
    rsp("lbu_000B", 32'h0000_0012, 1'b0);
    req(1'b0, 2'b01, 1'b0, 16'h000A, 32'd0);
    rsp("lh_000A", 32'h0000_1234, 1'b0);

    req(1'b1, 2'b00, 1'b0, 16'h0008, 32'h0000_00FF);
    rsp("sb_0008", 32'd0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 16'h0008, 32'd0);
    rsp("lw_0008_merged", 32'h1234_56FF, 1'b0);
    req(1'b0, 2'b00, 1'b0, 16'h0008, 32'd0);
    rsp("lb_0008", 32'hFFFF_FFFF, 1'b0);
    req(1'b0, 2'b00, 1'b1, 16'h0008, 32'd0);
    rsp("lbu_0008", 32'h0000_00FF, 1'b0);

    req(1'b1, 2'b10, 1'b0, 16'hFFFC, 32'hCAFE_F00D);
    rsp("sw_FFFC", 32'd0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 16'hFFFC, 32'd0);
    rsp("lw_FFFC", 32'hCAFE_F00D, 1'b0);
    req(1'b0, 2'b10, 1'b0, 16'h00FC, 32'd0);
    rsp("lw_00FC_heap_top", 32'h0000_0000, 1'b0);
    req(1'b0, 2'b01, 1'b0, 16'hFFFE, 32'd0);
    rsp("lh_FFFE_sign", 32'hFFFF_CAFE, 1'b0);

    req(1'b0, 2'b10, 1'b0, 16'h0100, 32'd0);
    rsp("err_lw_0100", 32'd0, 1'b1);
    req(1'b1, 2'b10, 1'b0, 16'hFEFC, 32'hDEAD_BEEF);
    rsp("err_sw_FEFC", 32'd0, 1'b1);
    req(1'b0, 2'b10, 1'b0, 16'hFF00, 32'd0);
    rsp("lw_FF00_stack_bottom", 32'h0000_0000, 1'b0);
    req(1'b0, 2'b10, 1'b0, 16'hFFFC, 32'd0);
    rsp("lw_FFFC_after_err", 32'hCAFE_F00D, 1'b0);
    req(1'b0, 2'b01, 1'b0, 16'h0001, 32'd0);
    rsp("err_lh_0001", 32'd0, 1'b1);
    req(1'b0, 2'b11, 1'b0, 16'h0008, 32'd0);
    rsp("err_size11", 32'd0, 1'b1);

    req(1'b1, 2'b10, 1'b0, 16'h0020, 32'hA5A5_A5A5);
    rsp("b2b0_sw_0020", 32'd0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 16'h0020, 32'd0);
    rsp("b2b1_lw_0020", 32'hA5A5_A5A5, 1'b0);
    req(1'b0, 2'b10, 1'b0, 16'h0024, 32'd0);
    rsp("b2b2_lw_0024", 32'h0000_0000, 1'b0);
    req(1'b1, 2'b10, 1'b0, 16'h0024, 32'h0000_0001);
    rsp("b2b3_sw_0024", 32'd0, 1'b0);
    @(posedge clock);
    #1;
    chk("idle.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    req(1'b0, 2'b10, 1'b0, 16'h0024, 32'd0);
    rsp("lw_0024_after_b2b", 32'h0000_0001, 1'b0);

    req(1'b0, 2'b10, 1'b0, 16'h0008, 32'd0);
    rsp("lw_0008_before_reset", 32'h1234_56FF, 1'b0);
    reset = 1'b1;
    #1;
    chk("midreset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("midreset.req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("midreset.init_done", {31'd0, init_done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_addr     = 16'h0008;
    wait_init("init2");
    bus.req_valid = 1'b0;

    req(1'b0, 2'b10, 1'b0, 16'h0008, 32'd0);
    rsp("lw_0008_recleared", 32'h0000_0000, 1'b0);
    req(1'b0, 2'b10, 1'b0, 16'hFFFC, 32'd0);
    rsp("lw_FFFC_recleared", 32'h0000_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stacked_data_memory.md
Name: stacked_data_memory

Overview:
- Parametrised next-generation data memory for the single-cycle MIPS datapath.
- Two physical arrays: heap, for non-negative addresses, and stack, for negative addresses.
- Byte-addressed, with byte, half and word loads/stores and sign/zero extension on loads.
- Valid/ready request handshake, 1-cycle registered response, error reporting, and a post-reset clear sequencer.

Parameters:
- ADDR_W, 16, width of the signed byte address (two's complement).
- HEAP_DEPTH, 64, number of 32-bit words in the heap array.
- STACK_DEPTH, 64, number of 32-bit words in the stack array.
- INIT_CLEAR, 1, 1 = zero both arrays after reset; 0 = skip the clear.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  signed byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response pulse, one per accepted request
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_error  out  1  accepted request was illegal
- init_done  out  1  clear sequence finished

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While reset is high: FSM = INIT, clear counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, init_done = 0.
- FSM states: INIT and RUN.
  - INIT with INIT_CLEAR=1: each cycle, write 0 to heap[cnt] if cnt < HEAP_DEPTH and to stack[cnt] if cnt < STACK_DEPTH. Increment cnt. After cnt = max(HEAP_DEPTH, STACK_DEPTH)-1 is written, move to RUN.
  - INIT with INIT_CLEAR=0: move to RUN on the first clock after reset deasserts.
  - RUN: init_done = 1, req_ready = 1. Stays in RUN until reset.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - req_valid while req_ready = 0 is ignored; no response is produced.
  - One request is accepted per cycle, back-to-back with no bubbles.
- Address decode:
  - word index w = req_addr >>> 2 (arithmetic shift); byte offset o = req_addr[1:0].
  - req_addr >= 0: heap[w], legal if w < HEAP_DEPTH.
  - req_addr < 0: stack[STACK_DEPTH + w], legal if w >= -STACK_DEPTH. Example: addr -4 maps to stack[STACK_DEPTH-1].
- Errors, any of:
  - out-of-range word index;
  - req_size = 11;
  - half access with o[0] = 1;
  - word access with o != 0.
  - On error: no array write, rsp_error = 1, rsp_rdata = 0.
- Stores:
  - Little-endian byte lanes.
  - byte: lane o <= wdata[7:0].
  - half: lanes o, o+1 <= wdata[15:0].
  - word: all four lanes <= wdata.
  - Other lanes are preserved. The array is updated on the accepting edge.
- Loads:
  - Selected lane(s) are right-aligned, then sign- or zero-extended to 32 bits per req_unsigned.
  - A word load ignores req_unsigned.
- Latency:
  - rsp_valid, rsp_rdata and rsp_error are registered and valid in the cycle after acceptance.
  - rsp_valid is a single-cycle pulse, deasserted in any cycle that follows a non-accept cycle.
- Ordering: a load accepted the cycle after a store to the same word returns the stored data.
- Reset mid-operation: the in-flight response is dropped (rsp_valid forced to 0 asynchronously), the FSM re-enters INIT, and the clear repeats if INIT_CLEAR=1.
- Heap and stack are independent: a heap access never alters the stack and vice versa.

Optional Feature:
- Macro: STACKED_MEM_STATS_EN.
- When defined, three extra outputs:
  - load_count (32): accepted legal loads;
  - store_count (32): accepted legal stores;
  - error_count (32): accepted illegal requests.
- All three reset to 0, increment in the cycle the request is accepted, and wrap at 2^32.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Defaults used. Release reset -> req_ready = 0 and init_done = 0 for exactly 64 cycles, then both 1. Load word at 0x0010 -> rsp_rdata 0x00000000, rsp_error 0.
- Lane access:
  - Store word 0x12345678 at 0x0008. Then:
    - unsigned byte load at 0x000B -> 0x00000012;
    - signed half load at 0x000A -> 0x00001234.
  - Store byte 0xFF at 0x0008. Then:
    - word load at 0x0008 -> 0x123456FF;
    - signed byte load at 0x0008 -> 0xFFFFFFFF.
- Stack: store word 0xCAFEF00D at 0xFFFC (-4) -> load at 0xFFFC returns 0xCAFEF00D. Heap word 63 (0x00FC) still reads 0.
- Errors, each -> rsp_error 1 and rsp_rdata 0:
  - load at 0x0100;
  - store at 0xFEFC (-260), after which the next legal stack reads are unchanged;
  - half load at 0x0001;
  - req_size 11.
- Throughput: req_valid held for 4 cycles (store 0xA5A5A5A5 at 0x0020, load 0x0020, load 0x0024, store 0x1 at 0x0024) -> 4 consecutive rsp_valid pulses at latency 1, with the load at 0x0020 returning 0xA5A5A5A5.
- Reset in RUN, the cycle after a load is accepted -> rsp_valid 0 immediately, INIT repeats for 64 cycles, and afterwards 0x0008 and 0xFFFC read 0.
